// File: rtl/riscky_pkg.sv
// Shared types and constants for the riscky RV32I core.
package riscky_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register: MSB is the valid flag; clear drops only valid, load captures all, else hold.
module if_id_reg #(
  parameter int W = 97
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q[W-1] <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC/FSM plus IF/ID register, one instr/cycle, stall holds everything.
// FETCH_PERF_CNT_EN adds fetch and stall event counters.
module fetch_stage
  import riscky_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic            halted_o,
  output logic            fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     stall_cnt_o
`endif
);

  localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_DEPTH * 4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            load, clear, bad_target;
  if_id_t          if_id_d, if_id_q;

  assign pc_plus4   = pc_q + XLEN'(4);
  assign bad_target = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i >= IMEM_BYTES);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_i) begin
          clear = 1'b1;
          if (bad_target) state_d = FAULT;
          else            pc_d    = redirect_pc_i;
        end else if (flush_i) begin
          // A concurrent stall still owns the PC.
          clear = 1'b1;
          if (!stall_i) pc_d = pc_plus4;
        end else if (stall_i) begin
          // hold
        end else if (pc_q >= IMEM_BYTES) begin
          state_d = FAULT;
          clear   = 1'b1;
        end else begin
          load = 1'b1;
          if (imem_rdata_i == HALT_INSTR) state_d = HALT;
          else                            pc_d    = pc_plus4;
        end
      end
      HALT: begin
        if (redirect_i) begin
          clear = 1'b1;
          if (bad_target) begin
            state_d = FAULT;
          end else begin
            state_d = RUN;
            pc_d    = redirect_pc_i;
          end
        end else if (!stall_i || flush_i) begin
          clear = 1'b1;
        end
      end
      FAULT: clear = 1'b1;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    if_id_d.valid = 1'b1;
    if_id_d.instr = imem_rdata_i;
    if_id_d.pc    = pc_q;
    if_id_d.pc4   = pc_plus4;
  end

  if_id_reg #(.W($bits(if_id_t))) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (clear),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = if_id_q.valid;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign halted_o      = (state_q == HALT);
  assign fault_o       = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic stall_event;
  assign stall_event = (state_q == RUN) && stall_i && !redirect_i && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (load)        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall_event) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid, halted, fault;
  logic [31:0] instr, pc, pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[11:2]];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .if_id_valid_o (valid),
    .if_id_instr_o (instr),
    .if_id_pc_o    (pc),
    .if_id_pc4_o   (pc4),
    .halted_o      (halted),
    .fault_o       (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt),
    .stall_cnt_o   (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({valid, instr, pc, pc4} !== 97'h0) begin
      failures++; $display("FAIL reset_if_id got=%h exp=0", {valid, instr, pc, pc4});
    end
    checks++;
    if ({imem_addr, halted, fault} !== 34'h0) begin
      failures++; $display("FAIL reset_pc_flags got addr=%h h=%b f=%b exp 0", imem_addr, halted, fault);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step();  // BOOT edge
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL boot_cycle got valid=%b addr=%h exp valid=0 addr=0", valid, imem_addr);
    end
  endtask

  task automatic test_seq_fetch();
    step();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h002082B3 || pc4 !== 32'h4) begin
      failures++; $display("FAIL fetch0 got v=%b pc=%h i=%h pc4=%h", valid, pc, instr, pc4);
    end
    step();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h005182B3 || imem_addr !== 32'h8) begin
      failures++; $display("FAIL fetch4 got v=%b pc=%h i=%h addr=%h", valid, pc, instr, imem_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h4 || valid !== 1'b1 || imem_addr !== 32'h8) begin
        failures++; $display("FAIL stall_hold cyc=%0d got pc=%h v=%b addr=%h exp pc=4 v=1 addr=8", i, pc, valid, imem_addr);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h8 || instr !== 32'h005202B3 || valid !== 1'b1 || imem_addr !== 32'hC) begin
      failures++; $display("FAIL stall_release got pc=%h i=%h v=%b addr=%h", pc, instr, valid, imem_addr);
    end
  endtask

  task automatic test_halt();
    step();
    checks++;
    if (instr !== 32'h00000073 || valid !== 1'b1 || halted !== 1'b1 || pc !== 32'hC) begin
      failures++; $display("FAIL halt_capture got i=%h v=%b h=%b pc=%h", instr, valid, halted, pc);
    end
    step();
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'hC || halted !== 1'b1) begin
      failures++; $display("FAIL halt_drain got v=%b addr=%h h=%b exp v=0 addr=c h=1", valid, imem_addr, halted);
    end
    step();
    checks++;
    if (imem_addr !== 32'hC || halted !== 1'b1) begin
      failures++; $display("FAIL halt_frozen got addr=%h h=%b", imem_addr, halted);
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    checks++;
    if (halted !== 1'b0 || imem_addr !== 32'h0 || valid !== 1'b0) begin
      failures++; $display("FAIL halt_resume got h=%b addr=%h v=%b exp h=0 addr=0 v=0", halted, imem_addr, valid);
    end
    step();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL resume_fetch got v=%b pc=%h addr=%h", valid, pc, imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'h40 || valid !== 1'b0) begin
      failures++; $display("FAIL redirect_pc got addr=%h v=%b exp addr=40 v=0", imem_addr, valid);
    end
    step();
    checks++;
    if (pc !== 32'h40 || valid !== 1'b1 || instr !== 32'h00000813 || pc4 !== 32'h44) begin
      failures++; $display("FAIL redirect_capture got pc=%h v=%b i=%h pc4=%h", pc, valid, instr, pc4);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h48) begin
      failures++; $display("FAIL flush got v=%b addr=%h exp v=0 addr=48", valid, imem_addr);
    end
    stall = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h48) begin
      failures++; $display("FAIL flush_stall got v=%b addr=%h exp v=0 addr=48", valid, imem_addr);
    end
    stall = 1'b0; flush = 1'b0;
    step();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h48 || instr !== 32'h00000913) begin
      failures++; $display("FAIL flush_resume got v=%b pc=%h i=%h", valid, pc, instr);
    end
  endtask

  task automatic test_fault_misaligned();
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'h4C) begin
      failures++; $display("FAIL fault_misalign got f=%b v=%b addr=%h exp f=1 v=0 addr=4c", fault, valid, imem_addr);
    end
    stall = 1'b1; step(); stall = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0; step(); redirect = 1'b0;
    step();
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'h4C) begin
      failures++; $display("FAIL fault_sticky got f=%b v=%b addr=%h", fault, valid, imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
      failures++; $display("FAIL fault_reset got f=%b addr=%h h=%b exp all 0", fault, imem_addr, halted);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step();  // BOOT
  endtask

  task automatic test_boundary();
    redirect = 1'b1; redirect_pc = 32'hFFC;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFC || fault !== 1'b0) begin
      failures++; $display("FAIL edge_redirect got addr=%h f=%b exp addr=ffc f=0", imem_addr, fault);
    end
    step();
    checks++;
    if (valid !== 1'b1 || pc !== 32'hFFC || pc4 !== 32'h1000 || imem_addr !== 32'h1000) begin
      failures++; $display("FAIL edge_capture got v=%b pc=%h pc4=%h addr=%h", valid, pc, pc4, imem_addr);
    end
    step();
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0) begin
      failures++; $display("FAIL pc_overrun got f=%b v=%b exp f=1 v=0", fault, valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step();  // BOOT
    redirect = 1'b1; redirect_pc = 32'h1000;
    step();
    redirect = 1'b0;
    checks++;
    if (fault !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL fault_range got f=%b addr=%h exp f=1 addr=0", fault, imem_addr);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step();  // BOOT
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stall = (i == 3 || i == 7);
      step();
    end
    stall = 1'b0;
    checks++;
    if (fetch_cnt !== 32'd10 || stall_cnt !== 32'd2) begin
      failures++; $display("FAIL perf_counts got fetch=%0d stall=%0d exp 10/2", fetch_cnt, stall_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL perf_reset got fetch=%0d stall=%0d exp 0/0", fetch_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h002082B3;
    mem[1] = 32'h005182B3;
    mem[2] = 32'h005202B3;
    mem[3] = 32'h00000073;
    for (int i = 16; i < 32; i++) mem[i] = 32'h13 | (i << 7);
    mem[1023] = 32'h00000013;

    test_reset();
    test_seq_fetch();
    test_stall();
    test_halt();
    test_redirect_stall();
    test_flush();
    test_fault_misaligned();
    test_boundary();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
